// File: rtl/mmu_responder.sv
// mmu_responder: target end of the CPU memory request bus. It services byte
// and word reads and writes against an internal byte-addressed memory. The
// memory is little-endian and has a configurable number of wait states.
// Results come back with a one-cycle done pulse. Read data is held until the
// next read completes.
module mmu_responder #(
  parameter int    MEM_BYTES   = 65536,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mmu_req_op,
  input  logic        mmu_req_size,
  input  logic [15:0] mmu_req_addr,
  input  logic [15:0] mmu_req_wdata,
  output logic        mmu_resp_done,
  output logic [15:0] mmu_resp_rdata
);

  localparam logic [1:0] BUS_OP_IDLE    = 2'd0;
  localparam logic [1:0] BUS_OP_READ    = 2'd1;
  localparam logic [1:0] BUS_OP_WRITE   = 2'd2;
  localparam logic       BUS_SIZE_BYTE  = 1'b0;
  localparam logic       BUS_SIZE_WORD  = 1'b1;

  localparam int          AW         = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [16:0] MEM_LIMIT  = 17'(MEM_BYTES);
  localparam logic [3:0]  WAIT_LOAD  = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LO, S_ACC_LO, S_WAIT_HI, S_ACC_HI, S_RESP
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic        size_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [3:0]  wait_cnt;
  logic [7:0]  rdata_lo, rdata_hi;
  logic [7:0]  mem [MEM_BYTES];

  logic        req_valid;
  logic [15:0] acc_addr;
  logic        acc_mapped;
  logic [7:0]  rd_byte;
  logic        mem_we;
  logic [7:0]  mem_wbyte;
  logic        done_d;
  logic [15:0] rdata_d;

  // Encodings outside the enum (op == 3) never start a transaction.
  assign req_valid  = (mmu_req_op == BUS_OP_READ) || (mmu_req_op == BUS_OP_WRITE);
  assign acc_addr   = (state == S_ACC_HI) ? addr_q + 16'd1 : addr_q;
  assign acc_mapped = ({1'b0, acc_addr} < MEM_LIMIT);
  assign rd_byte    = acc_mapped ? mem[acc_addr[AW-1:0]] : 8'hFF;
  assign mem_wbyte  = (state == S_ACC_HI) ? wdata_q[15:8] : wdata_q[7:0];
  assign mem_we     = ((state == S_ACC_LO) || (state == S_ACC_HI)) &&
                      (op_q == BUS_OP_WRITE) && acc_mapped;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (req_valid) state_nxt = (WAIT_CYCLES == 0) ? S_ACC_LO : S_WAIT_LO;
      S_WAIT_LO: if (wait_cnt == 4'd0) state_nxt = S_ACC_LO;
      S_ACC_LO: begin
        if (size_q == BUS_SIZE_WORD)
          state_nxt = (WAIT_CYCLES == 0) ? S_ACC_HI : S_WAIT_HI;
        else
          state_nxt = S_RESP;
      end
      S_WAIT_HI: if (wait_cnt == 4'd0) state_nxt = S_ACC_HI;
      S_ACC_HI:  state_nxt = S_RESP;
      S_RESP:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Response values presented for the cycle following S_RESP.
  always_comb begin
    done_d  = (state == S_RESP);
    rdata_d = mmu_resp_rdata;
    if ((state == S_RESP) && (op_q == BUS_OP_READ))
      rdata_d = (size_q == BUS_SIZE_WORD) ? {rdata_hi, rdata_lo} : {8'h00, rdata_lo};
  end

  // Registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mmu_resp_done  <= 1'b0;
      mmu_resp_rdata <= 16'h0000;
    end else begin
      mmu_resp_done  <= done_d;
      mmu_resp_rdata <= rdata_d;
    end
  end

  // Request latch, wait down-counter and read byte capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= BUS_OP_IDLE;
      size_q   <= BUS_SIZE_BYTE;
      addr_q   <= 16'h0000;
      wdata_q  <= 16'h0000;
      wait_cnt <= 4'd0;
      rdata_lo <= 8'h00;
      rdata_hi <= 8'h00;
    end else begin
      if ((state == S_IDLE) && req_valid) begin
        op_q    <= mmu_req_op;
        size_q  <= mmu_req_size;
        addr_q  <= mmu_req_addr;
        wdata_q <= mmu_req_wdata;
      end
      // Counter sits at the reload value outside the wait states, so each
      // wait phase starts fresh.
      if (((state == S_WAIT_LO) || (state == S_WAIT_HI)) && (wait_cnt != 4'd0))
        wait_cnt <= wait_cnt - 4'd1;
      else
        wait_cnt <= WAIT_LOAD;
      if ((state == S_ACC_LO) && (op_q == BUS_OP_READ)) rdata_lo <= rd_byte;
      if ((state == S_ACC_HI) && (op_q == BUS_OP_READ)) rdata_hi <= rd_byte;
    end
  end

  // Byte-wide storage; not reset so memory survives a reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_addr[AW-1:0]] <= mem_wbyte;
  end

endmodule
